turbo_enc_qpp_agu: RTL
======================

TURBO_ENC_QPP_AGU -- requirements
Module: turbo_enc_qpp_agu

Interface
REQ-001 Parameter MAX_BLOCK_WIDTH, default 10, width of the block-size field; the block size is given in units of 4 bits.
REQ-002 Parameter P_WIDTH, default 10, width of the p0 step.
REQ-003 Parameter NUM_Q, default 4, number of q offsets; SHALL be a power of 2, range 2..8.
REQ-004 Parameter MAX_DATA_WIDTH, default MAX_BLOCK_WIDTH+2, width of all addresses.
REQ-005 i_clk  in  1  single clock, rising edge.
REQ-006 i_rstn  in  1  asynchronous, active-low reset.
REQ-007 i_block_size  in  MAX_BLOCK_WIDTH  block size; N = i_block_size*4.
REQ-008 i_mode  in  1  0 = linear read, 1 = interleaved (QPP) read.
REQ-009 i_ea  in  MAX_DATA_WIDTH  index of the last address issued.
REQ-010 i_p0  in  P_WIDTH  lambda step.
REQ-011 i_q  in  NUM_Q*MAX_DATA_WIDTH  q offsets; q[j] occupies slice j.
REQ-012 i_start  in  1  frame start request.
REQ-013 i_abort  in  1  cancels the current frame.
REQ-014 i_siso_ready  in  1  SISO buffer can accept data.
REQ-015 i_ib_data_ab  in  2  input-buffer read data, valid 1 cycle after o_ib_rd.
REQ-016 o_ib_adx_ab  out  MAX_DATA_WIDTH  input-buffer read address.
REQ-017 o_ib_rd  out  1  input-buffer read strobe.
REQ-018 o_siso_data_ab  out  2  data to the SISO buffer.
REQ-019 o_siso_buf_wr  out  1  SISO buffer write strobe.
REQ-020 o_read_done  out  1  one-cycle frame-complete pulse.
REQ-021 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-022 The block SHALL implement an FSM with states IDLE, GEN and DRAIN; all outputs are registered.
REQ-023 In IDLE, i_start=1 with i_abort=0 SHALL snapshot i_mode, i_ea, N, i_p0 and i_q, clear k and lambda, and move to GEN; i_start is ignored outside IDLE.
REQ-024 Sequence, for k = 0..ea:
- lambda_0 = 0.
- lambda_(k+1) = (lambda_k + p0) mod N.
- pi_k = (lambda_k + q[k mod NUM_Q]) mod N.
REQ-025 Each mod SHALL be computed as an add at MAX_DATA_WIDTH+1 bits plus one conditional subtraction of N; behaviour for p0 >= N or q >= N is unspecified.
REQ-026 In GEN, a cycle with i_siso_ready=1 SHALL issue address k:
- o_ib_rd=1.
- o_ib_adx_ab = k in mode 0, pi_k in mode 1.
- k and lambda advance.
REQ-027 In GEN, a cycle with i_siso_ready=0 SHALL set o_ib_rd=0; k, lambda and o_ib_adx_ab hold.
REQ-028 Each issued address SHALL produce exactly one o_siso_buf_wr, 2 cycles after its o_ib_rd, carrying i_ib_data_ab sampled 1 cycle after that o_ib_rd.
REQ-029 o_siso_data_ab SHALL be i_ib_data_ab with its bits swapped when mode=1 and pi_k[0]=0; otherwise it SHALL be unswapped.
REQ-030 After k=ea is issued the FSM SHALL enter DRAIN, then return to IDLE once the last write completes.
REQ-031 o_read_done SHALL pulse coincident with the last o_siso_buf_wr.
REQ-032 Writes already in flight SHALL complete regardless of i_siso_ready; the SISO buffer needs at most 2 entries of slack.
REQ-033 When i_abort=1 in GEN or DRAIN:
- the FSM enters IDLE on the next cycle;
- all in-flight o_siso_buf_wr are suppressed;
- o_read_done does not pulse.
REQ-034 i_abort in IDLE SHALL have no effect, and SHALL block a simultaneous i_start.
REQ-035 ea=0 SHALL produce a single-entry frame.
REQ-036 A new i_start SHALL be accepted on the cycle o_busy falls, with no dead cycle required beyond the return to IDLE.

Reset
REQ-037 With i_rstn=0, at any time including mid-frame, the block SHALL immediately:
- force the FSM to IDLE;
- clear k, lambda and the pipeline;
- drive o_ib_rd, o_siso_buf_wr, o_read_done, o_busy, o_ib_adx_ab and o_siso_data_ab to 0.
REQ-038 Operation SHALL resume on the first clock edge after i_rstn rises; no partial frame continues.

Verification
REQ-039 Linear frame: mode=0, ea=7, ready=1 -> addresses 0..7 on 8 consecutive cycles; 8 writes, unswapped; o_read_done coincides with the 8th write.
REQ-040 QPP frame, block_size=10 (N=40), p0=13, q={0,10,20,30}, mode=1:
- addresses 0, 23, 6, 29, 12, ...;
- swap on 0, 6 and 12; no swap on 23 and 29.
REQ-041 Backpressure: ready=0 for 3 cycles after k=3 ->
- o_ib_rd low for those 3 cycles;
- at most 2 writes continue;
- the sequence resumes at k=4 with no gap or repeat.
REQ-042 Abort at k=5 of an ea=15 frame -> IDLE next cycle, no further writes, no o_read_done; a following i_start runs a clean frame from k=0.
REQ-043 Reset mid-frame, plus start/abort collision in IDLE:
- i_rstn low at k=4 -> all outputs 0 at once, and a restart works;
- i_start and i_abort high together in IDLE -> the FSM stays in IDLE.
REQ-044 NUM_Q=8 build, ea=0 -> a single write carrying pi_0 = q[0] mod N; o_read_done pulses once.

Source files
------------

// File: rtl/turbo_enc_qpp_agu.sv
// rtl/turbo_enc_qpp_agu.sv - turbo encoder input-buffer address generator (linear / QPP)
// Issues one read per ready cycle and forwards the returned data to the SISO buffer 2 cycles later.
module turbo_enc_qpp_agu #(
  parameter int MAX_BLOCK_WIDTH = 10,
  parameter int P_WIDTH         = 10,
  parameter int NUM_Q           = 4,
  parameter int MAX_DATA_WIDTH  = MAX_BLOCK_WIDTH + 2
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [MAX_BLOCK_WIDTH-1:0]  i_block_size,
  input  logic                        i_mode,
  input  logic [MAX_DATA_WIDTH-1:0]   i_ea,
  input  logic [P_WIDTH-1:0]          i_p0,
  input  logic [NUM_Q*MAX_DATA_WIDTH-1:0] i_q,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_siso_ready,
  input  logic [1:0]                  i_ib_data_ab,
  output logic [MAX_DATA_WIDTH-1:0]   o_ib_adx_ab,
  output logic                        o_ib_rd,
  output logic [1:0]                  o_siso_data_ab,
  output logic                        o_siso_buf_wr,
  output logic                        o_read_done,
  output logic                        o_busy
);
  localparam int DW = MAX_DATA_WIDTH;
  localparam int QW = $clog2(NUM_Q);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic                       mode_q, mode_d;
  logic [DW-1:0]              ea_q, ea_d;
  logic [DW:0]                n_q, n_d;
  logic [DW:0]                p0_q, p0_d;
  logic [NUM_Q-1:0][DW-1:0]   q_q, q_d;
  logic [DW-1:0]              k_q, k_d;
  logic [DW-1:0]              lambda_q, lambda_d;
  logic [DW-1:0]              adx_q, adx_d;
  logic                       rd_q, rd_d, rd_swap_q, rd_swap_d, rd_last_q, rd_last_d;
  logic                       s1_q, s1_d, s1_swap_q, s1_swap_d, s1_last_q, s1_last_d;
  logic                       wr_q, wr_d, done_q, done_d, busy_q, busy_d;
  logic [1:0]                 data_q, data_d;
  logic [DW-1:0]              pi, lambda_nxt;

  // Operands are < N, so one conditional subtraction completes the reduction.
  function automatic logic [DW-1:0] mod_add(input logic [DW:0] a, input logic [DW:0] b,
                                            input logic [DW:0] n);
    logic [DW:0] s;
    s = a + b;
    if (s >= n) s = s - n;
    return s[DW-1:0];
  endfunction

  assign pi         = mod_add({1'b0, lambda_q}, {1'b0, q_q[k_q[QW-1:0]]}, n_q);
  assign lambda_nxt = mod_add({1'b0, lambda_q}, p0_q, n_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ea_d      = ea_q;
    n_d       = n_q;
    p0_d      = p0_q;
    q_d       = q_q;
    k_d       = k_q;
    lambda_d  = lambda_q;
    adx_d     = adx_q;
    rd_d      = 1'b0;
    rd_swap_d = rd_swap_q;
    rd_last_d = 1'b0;
    s1_d      = rd_q;
    s1_swap_d = rd_swap_q;
    s1_last_d = rd_last_q;
    wr_d      = s1_q;
    data_d    = data_q;
    done_d    = s1_q & s1_last_q;
    if (s1_q) data_d = s1_swap_q ? {i_ib_data_ab[0], i_ib_data_ab[1]} : i_ib_data_ab;

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          mode_d   = i_mode;
          ea_d     = i_ea;
          n_d      = '0;
          n_d[MAX_BLOCK_WIDTH+1:0] = {i_block_size, 2'b00};
          p0_d     = '0;
          p0_d[P_WIDTH-1:0] = i_p0;
          q_d      = i_q;
          k_d      = '0;
          lambda_d = '0;
          state_d  = GEN;
        end
      end
      GEN: begin
        if (i_siso_ready) begin
          rd_d      = 1'b1;
          adx_d     = mode_q ? pi : k_q;
          rd_swap_d = mode_q & ~pi[0];
          rd_last_d = (k_q == ea_q);
          k_d       = k_q + 1'b1;
          lambda_d  = lambda_nxt;
          if (k_q == ea_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort flushes the whole read/write pipeline so no stale write or done escapes.
    if (i_abort && state_q != IDLE) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      s1_d    = 1'b0;
      wr_d    = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      ea_q      <= '0;
      n_q       <= '0;
      p0_q      <= '0;
      q_q       <= '0;
      k_q       <= '0;
      lambda_q  <= '0;
      adx_q     <= '0;
      rd_q      <= 1'b0;
      rd_swap_q <= 1'b0;
      rd_last_q <= 1'b0;
      s1_q      <= 1'b0;
      s1_swap_q <= 1'b0;
      s1_last_q <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ea_q      <= ea_d;
      n_q       <= n_d;
      p0_q      <= p0_d;
      q_q       <= q_d;
      k_q       <= k_d;
      lambda_q  <= lambda_d;
      adx_q     <= adx_d;
      rd_q      <= rd_d;
      rd_swap_q <= rd_swap_d;
      rd_last_q <= rd_last_d;
      s1_q      <= s1_d;
      s1_swap_q <= s1_swap_d;
      s1_last_q <= s1_last_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign o_ib_adx_ab    = adx_q;
  assign o_ib_rd        = rd_q;
  assign o_siso_data_ab = data_q;
  assign o_siso_buf_wr  = wr_q;
  assign o_read_done    = done_q;
  assign o_busy         = busy_q;
endmodule
